// File: rtl/psum_accumulator.sv
// Accumulates NUM_OUT partial-sum vectors lane-wise across KIJ_LEN kernel passes,
// then streams the ReLU'd buffer out over a valid/ready interface.
module psum_accumulator #(
  parameter int COL     = 4,
  parameter int PSUM_BW = 16,
  parameter int NUM_OUT = 8,
  parameter int KIJ_LEN = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   iter_done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COL*PSUM_BW-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COL*PSUM_BW-1:0] out_data,
  output logic                   busy,
  output logic                   acc_done,
  output logic                   err_short
);

  localparam int DW = COL * PSUM_BW;
  localparam int VW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int KW = (KIJ_LEN > 1) ? $clog2(KIJ_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_WAIT_ITER,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   kij_cnt_q, kij_cnt_d;
  logic [VW-1:0]   vec_cnt_q, vec_cnt_d;
  logic [VW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            err_short_q, err_short_d;
  logic [DW-1:0]   buf_q [NUM_OUT];
  logic [DW-1:0]   acc_sum;
  logic            in_hs, out_hs;

  // All handshake-facing outputs decode straight from registered state.
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q != S_IDLE);
  assign acc_done  = (state_q == S_DONE);
  assign err_short = err_short_q;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    kij_cnt_d   = kij_cnt_q;
    vec_cnt_d   = vec_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    err_short_d = err_short_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          kij_cnt_d   = '0;
          vec_cnt_d   = '0;
          err_short_d = 1'b0;
          state_d     = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (iter_done) err_short_d = 1'b1;
        if (in_hs) begin
          if (vec_cnt_q == VW'(NUM_OUT - 1)) begin
            vec_cnt_d = '0;
            state_d   = S_WAIT_ITER;
          end else begin
            vec_cnt_d = vec_cnt_q + VW'(1);
          end
        end
      end
      S_WAIT_ITER: begin
        if (iter_done) begin
          if (kij_cnt_q == KW'(KIJ_LEN - 1)) begin
            rd_ptr_d = '0;
            state_d  = S_DRAIN;
          end else begin
            kij_cnt_d = kij_cnt_q + KW'(1);
            state_d   = S_ACCUM;
          end
        end
      end
      S_DRAIN: begin
        if (out_hs) begin
          if (rd_ptr_q == VW'(NUM_OUT - 1)) begin
            rd_ptr_d = '0;
            state_d  = S_DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + VW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kij_cnt_q   <= '0;
      vec_cnt_q   <= '0;
      rd_ptr_q    <= '0;
      err_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kij_cnt_q   <= kij_cnt_d;
      vec_cnt_q   <= vec_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      err_short_q <= err_short_d;
    end
  end

  // Lane-wise wrap-around add; the first pass overwrites instead of adding.
  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < COL; k++) begin
      if (kij_cnt_q == '0)
        acc_sum[k*PSUM_BW +: PSUM_BW] = in_data[k*PSUM_BW +: PSUM_BW];
      else
        acc_sum[k*PSUM_BW +: PSUM_BW] = buf_q[vec_cnt_q][k*PSUM_BW +: PSUM_BW]
                                      + in_data[k*PSUM_BW +: PSUM_BW];
    end
  end

  // NOTE: the buffer has no reset; pass 0 overwrites every entry before it is ever read.
  always_ff @(posedge clk) begin
    if (!reset && in_hs) buf_q[vec_cnt_q] <= acc_sum;
  end

  // Buffer is not written during DRAIN, so out_data holds steady across stalls.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < COL; k++) begin
      if (!buf_q[rd_ptr_q][k*PSUM_BW + PSUM_BW - 1])
        out_data[k*PSUM_BW +: PSUM_BW] = buf_q[rd_ptr_q][k*PSUM_BW +: PSUM_BW];
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized bench for psum_accumulator: a reference model fills a scoreboard
// queue per run, and a negedge monitor compares every presented output vector.
module tb_psum_accumulator;

  localparam int COL     = 4;
  localparam int PSUM_BW = 16;
  localparam int NUM_OUT = 8;
  localparam int KIJ_LEN = 9;
  localparam int DW      = COL * PSUM_BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          iter_done;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          acc_done;
  logic          err_short;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]      exp_q [$];
  logic [PSUM_BW-1:0] dat [KIJ_LEN][NUM_OUT][COL];

  always #5 clk = ~clk;

  psum_accumulator #(
    .COL(COL), .PSUM_BW(PSUM_BW), .NUM_OUT(NUM_OUT), .KIJ_LEN(KIJ_LEN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .iter_done(iter_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .acc_done(acc_done), .err_short(err_short)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents data it must equal the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_spurious", 64'(exp_q.size()), 64'd1);
        end else begin
          check("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // mode 0: all ones, 1: signed lane pattern, 2: wrap case, 3: random, 4: all twos
  function automatic logic [PSUM_BW-1:0] gen(input int mode, input int l);
    logic [PSUM_BW-1:0] v;
    v = '0;
    case (mode)
      0: v = 16'd1;
      1: case (l)
           0: v = 16'hFFFD;
           1: v = 16'd2;
           2: v = 16'd0;
           default: v = 16'd7;
         endcase
      2: v = (l == 0) ? 16'h7000 : (l == 1) ? 16'h0100 : 16'h0000;
      3: v = PSUM_BW'($urandom_range(0, 65535));
      default: v = 16'd2;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int mode, input int rdy_mode, input bit short_pass, input bit reset_in_drain);
    logic [DW-1:0]      e;
    logic [DW-1:0]      v_data;
    logic [PSUM_BW-1:0] s;
    int                 sum;
    int                 n;
    int                 c;
    int                 hs_cnt;
    bit                 hs;

    // Reference model: plain sum of every pass, truncated, then ReLU.
    for (int k = 0; k < KIJ_LEN; k++)
      for (int v = 0; v < NUM_OUT; v++)
        for (int l = 0; l < COL; l++)
          dat[k][v][l] = gen(mode, l);
    for (int v = 0; v < NUM_OUT; v++) begin
      e = '0;
      for (int l = 0; l < COL; l++) begin
        sum = 0;
        for (int k = 0; k < KIJ_LEN; k++) sum += int'(dat[k][v][l]);
        s = sum[PSUM_BW-1:0];
        e[l*PSUM_BW +: PSUM_BW] = s[PSUM_BW-1] ? '0 : s;
      end
      exp_q.push_back(e);
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_err_clear", err_short, 1'b0);
    check("start_in_ready", in_ready, 1'b1);

    for (int k = 0; k < KIJ_LEN; k++) begin
      for (int v = 0; v < NUM_OUT; v++) begin
        if (short_pass && k == 2 && v == 5) begin
          iter_done = 1'b1;
          in_valid  = 1'b0;
          tick();
          iter_done = 1'b0;
          check("short_err_set", err_short, 1'b1);
          check("short_stay_accum", in_ready, 1'b1);
        end
        if (mode == 3) begin
          repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            in_data  = DW'({$urandom, $urandom});
            tick();
          end
        end
        for (int l = 0; l < COL; l++) v_data[l*PSUM_BW +: PSUM_BW] = dat[k][v][l];
        in_valid = 1'b1;
        in_data  = v_data;
        if (short_pass && k == 5 && v == NUM_OUT - 1) iter_done = 1'b1;
        n = 0;
        do begin
          hs = in_ready;
          tick();
          n++;
        end while (!hs && n < 20);
        iter_done = 1'b0;
        if (!hs) check("in_accept", hs, 1'b1);
      end
      // WAIT_ITER must ignore in_valid; drive garbage for a few cycles.
      in_valid = (mode == 3);
      in_data  = DW'({$urandom, $urandom});
      check("wait_in_ready", in_ready, 1'b0);
      if (mode == 3) repeat ($urandom_range(0, 2)) tick();
      in_valid  = 1'b0;
      iter_done = 1'b1;
      tick();
      iter_done = 1'b0;
      if (k < KIJ_LEN - 1) check("next_pass_accum", in_ready, 1'b1);
    end
    check("drain_first_valid", out_valid, 1'b1);

    c = 0;
    hs_cnt = 0;
    while (out_valid && c < 100) begin
      if (reset_in_drain && hs_cnt == 3) break;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      hs = out_ready;
      tick();
      c++;
      if (hs) hs_cnt++;
    end
    out_ready = 1'b0;

    if (reset_in_drain) begin
      check("pre_reset_hs", 64'(hs_cnt), 64'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err_short", err_short, 1'b0);
      check("rst_acc_done", acc_done, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      exp_q.delete();
    end else begin
      check("drain_handshakes", 64'(hs_cnt), 64'd8);
      if (rdy_mode == 0) check("drain_len_full", 64'(c), 64'd8);
      if (rdy_mode == 1) check("drain_len_alt", 64'(c), 64'd15);
      check("acc_done_pulse", acc_done, 1'b1);
      check("done_out_valid", out_valid, 1'b0);
      check("err_short_end", err_short, short_pass);
      tick();
      check("acc_done_once", acc_done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    iter_done = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    check("reset_busy", busy, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_acc_done", acc_done, 1'b0);
    check("reset_err_short", err_short, 1'b0);
    reset = 1'b0;
    tick();
    check("idle_no_start", busy, 1'b0);

    run(0, 0, 1'b0, 1'b0);  // all ones -> 9
    run(1, 0, 1'b0, 1'b0);  // signed lanes with ReLU
    run(2, 0, 1'b0, 1'b0);  // lane wrap to negative
    run(3, 1, 1'b0, 1'b0);  // alternating out_ready
    run(3, 2, 1'b1, 1'b0);  // short pass sets sticky err_short
    run(3, 0, 1'b0, 1'b0);  // next start clears err_short
    run(3, 0, 1'b1, 1'b1);  // reset mid-drain
    run(4, 0, 1'b0, 1'b0);  // fresh run after reset -> 18
    run(3, 2, 1'b0, 1'b0);
    run(3, 2, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
